fp_mul_seq: RTL

Parametrised, iterative IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. It computes the mantissa product with a radix-4 Booth loop over multiple cycles, then normalises, rounds (five modes) and flags exceptions. It replaces the single-cycle FP32 multiplier in the ALU wherever area matters more than latency. Subnormal operands and results are flushed to zero.

---
 rtl/fp_mul_seq_if.sv | 32 +++
 rtl/fp_mul_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq_if.sv
// Handshake bundle for fp_mul_seq: operand channel in, result channel plus exception flags out.
interface fp_mul_seq_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) ();
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] fp_X;
  logic [W-1:0] fp_Y;
  logic [2:0]   r_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] fp_Z;
  logic         ovrf;
  logic         udrf;
  logic         zer;
  logic         inf;
  logic         nan;
  logic         nx;

  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf, zer, inf, nan, nx
  );

  modport master (
    output in_valid, fp_X, fp_Y, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf, zer, inf, nan, nx
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Iterative FP multiplier: radix-4 Booth mantissa loop, normalise, five rounding modes, FTZ.
// FP_MUL_STICKY_FLAGS_EN adds flags_clr / sticky_flags accumulating result flags over handshakes.
module fp_mul_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic       clk,
  input  logic       rst,
  fp_mul_seq_if.slave bus
`ifdef FP_MUL_STICKY_FLAGS_EN
  ,
  input  logic       flags_clr,
  output logic [5:0] sticky_flags
`endif
);
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int N    = FRAC_W + 1;
  localparam int PW   = 2 * N;
  localparam int ITER = (FRAC_W + 3) / 2;
  localparam int MW   = 2 * ITER;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] BIAS_E   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX_E   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_E   = '0;
  localparam logic [2:0] RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3, RM_RMM = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;

  state_t                state_q;
  logic [W-1:0]          x_q, y_q, z_q;
  logic [2:0]            rm_q;
  logic                  sign_q, spec_wait_q, prev_q;
  logic [PW-1:0]         mcand_q, p_q;
  logic [MW-1:0]         mplr_q;
  logic [CW-1:0]         cnt_q;
  logic signed [EW-1:0]  exp_q;
  logic [N-1:0]          mant_q;
  logic                  g_q, r_q, s_q;
  logic                  out_valid_q, ovrf_q, udrf_q, zer_q, inf_q, nan_q, nx_q;

  // Operand decode from the captured raw words
  logic [EXP_W-1:0]  x_exp, y_exp;
  logic [FRAC_W-1:0] x_frac, y_frac;
  logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic              sign_d, spec_nan_d, spec_inf_d, spec_zer_d;
  logic [W-1:0]      spec_z_d;

  always_comb begin
    x_exp      = x_q[W-2 -: EXP_W];
    y_exp      = y_q[W-2 -: EXP_W];
    x_frac     = x_q[FRAC_W-1:0];
    y_frac     = y_q[FRAC_W-1:0];
    x_zero     = (x_exp == '0);
    y_zero     = (y_exp == '0);
    x_inf      = (x_exp == EXP_ONES) && (x_frac == '0);
    y_inf      = (y_exp == EXP_ONES) && (y_frac == '0);
    x_nan      = (x_exp == EXP_ONES) && (x_frac != '0);
    y_nan      = (y_exp == EXP_ONES) && (y_frac != '0);
    sign_d     = x_q[W-1] ^ y_q[W-1];
    spec_nan_d = x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf);
    spec_inf_d = !spec_nan_d && (x_inf || y_inf);
    spec_zer_d = !spec_nan_d && !spec_inf_d && (x_zero || y_zero);
    if (spec_nan_d)      spec_z_d = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
    else if (spec_inf_d) spec_z_d = {sign_d, EXP_ONES, {FRAC_W{1'b0}}};
    else                 spec_z_d = {sign_d, {(W-1){1'b0}}};
  end

  // Booth digit from {b(2i+1), b(2i), b(2i-1)}; the product register wraps mod 2^PW harmlessly
  logic [PW-1:0] pp_d;
  always_comb begin
    unique case ({mplr_q[1:0], prev_q})
      3'b001, 3'b010: pp_d = mcand_q;
      3'b011:         pp_d = mcand_q << 1;
      3'b100:         pp_d = -(mcand_q << 1);
      3'b101, 3'b110: pp_d = -mcand_q;
      default:        pp_d = '0;
    endcase
  end

  logic [PW-1:0] pn_d;
  always_comb pn_d = p_q[PW-1] ? p_q : (p_q << 1);

  logic                 inc_d, nx_d, ovf_d, udf_d, to_inf_d;
  logic [N:0]           mant_r;
  logic [FRAC_W-1:0]    frac_r;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]         z_d;
  always_comb begin
    nx_d = g_q | r_q | s_q;
    unique case (rm_q)
      RM_RTZ:  inc_d = 1'b0;
      RM_RDN:  inc_d = nx_d & sign_q;
      RM_RUP:  inc_d = nx_d & ~sign_q;
      RM_RMM:  inc_d = g_q;
      default: inc_d = g_q & (r_q | s_q | mant_q[0]);
    endcase
    mant_r   = {1'b0, mant_q} + {{N{1'b0}}, inc_d};
    frac_r   = mant_r[N] ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
    e_r      = exp_q + {{(EW-1){1'b0}}, mant_r[N]};
    ovf_d    = (e_r >= EMAX_E);
    udf_d    = !ovf_d && (e_r <= ZERO_E);
    to_inf_d = (rm_q == RM_RNE) || (rm_q == RM_RMM) ||
               ((rm_q == RM_RUP) && !sign_q) || ((rm_q == RM_RDN) && sign_q);
    if (ovf_d && to_inf_d) z_d = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
    else if (ovf_d)        z_d = {sign_q, EXP_ONES - EXP_W'(1), {FRAC_W{1'b1}}};
    else if (udf_d)        z_d = {sign_q, {(W-1){1'b0}}};
    else                   z_d = {sign_q, e_r[EXP_W-1:0], frac_r};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      {ovrf_q, udrf_q, zer_q, inf_q, nan_q, nx_q} <= '0;
      spec_wait_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.in_valid) begin
          x_q         <= bus.fp_X;
          y_q         <= bus.fp_Y;
          rm_q        <= (bus.r_mode > RM_RMM) ? RM_RNE : bus.r_mode;
          spec_wait_q <= 1'b0;
          state_q     <= S_UNPACK;
        end
        S_UNPACK: begin
          sign_q <= sign_d;
          if (spec_nan_d || spec_inf_d || spec_zer_d) begin
            // Special results spend a second UNPACK cycle before DONE
            spec_wait_q <= 1'b1;
            if (spec_wait_q) begin
              z_q         <= spec_z_d;
              {ovrf_q, udrf_q, zer_q, inf_q, nan_q, nx_q} <=
                {1'b0, 1'b0, spec_zer_d, spec_inf_d, spec_nan_d, 1'b0};
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end else begin
            mcand_q <= PW'({1'b1, x_frac});
            mplr_q  <= MW'({1'b1, y_frac});
            prev_q  <= 1'b0;
            p_q     <= '0;
            cnt_q   <= '0;
            exp_q   <= $signed({2'b00, x_exp}) + $signed({2'b00, y_exp}) - BIAS_E;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          p_q     <= p_q + pp_d;
          mcand_q <= mcand_q << 2;
          mplr_q  <= mplr_q >> 2;
          prev_q  <= mplr_q[1];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) state_q <= S_NORM;
        end
        S_NORM: begin
          mant_q  <= pn_d[PW-1 -: N];
          g_q     <= pn_d[N-1];
          r_q     <= pn_d[N-2];
          s_q     <= |pn_d[N-3:0];
          exp_q   <= exp_q + {{(EW-1){1'b0}}, p_q[PW-1]};
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          z_q         <= z_d;
          ovrf_q      <= ovf_d;
          udrf_q      <= udf_d;
          zer_q       <= udf_d;
          inf_q       <= ovf_d && to_inf_d;
          nan_q       <= 1'b0;
          nx_q        <= nx_d || ovf_d || udf_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.fp_Z      = z_q;
  assign bus.ovrf      = ovrf_q;
  assign bus.udrf      = udrf_q;
  assign bus.zer       = zer_q;
  assign bus.inf       = inf_q;
  assign bus.nan       = nan_q;
  assign bus.nx        = nx_q;

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic [5:0] sticky_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      sticky_q <= (flags_clr ? 6'd0 : sticky_q) | {nx_q, nan_q, inf_q, zer_q, udrf_q, ovrf_q};
    end else if (flags_clr) begin
      sticky_q <= '0;
    end
  end
  assign sticky_flags = sticky_q;
`endif
endmodule
